// File: rtl/ulpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_pkg
// Purpose  : Shared FSM state encoding and ULPI byte constants for the link
//            controller. Macro ULPI_EXT_REG_EN adds the EXT_ADDR state.
// Revision : 1.0 - initial release
// ============================================================================
package ulpi_pkg;

`ifdef ULPI_EXT_REG_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TXCMD    = 3'd1,
    ST_WDATA    = 3'd2,
    ST_STP      = 3'd3,
    ST_RD_TURN  = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_EXT_ADDR = 3'd6
  } ulpi_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TXCMD    = 3'd1,
    ST_WDATA    = 3'd2,
    ST_STP      = 3'd3,
    ST_RD_TURN  = 3'd4,
    ST_RD_DATA  = 3'd5
  } ulpi_state_t;
`endif

  localparam logic [7:0] c_noop       = 8'h00;
  localparam logic [1:0] c_pfx_write  = 2'b10;
  localparam logic [1:0] c_pfx_read   = 2'b11;
  localparam logic [5:0] c_ext_escape = 6'h2F;

  function automatic logic [7:0] txcmd_byte(input logic i_we, input logic [5:0] i_addr);
    return {(i_we ? c_pfx_write : c_pfx_read), i_addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ulpi_rx_decode.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_rx_decode
// Purpose  : Bus turnaround detection and RX CMD / RX data capture while the
//            PHY owns the bus.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_rx_decode (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_dir,
  input  logic       i_nxt,
  input  logic [7:0] i_data,
  input  logic       i_suppress,
  output logic       o_turnaround,
  output logic [7:0] o_rx_cmd,
  output logic       o_rx_cmd_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid
);

  logic       r_dir_q;
  logic [7:0] r_rx_cmd;
  logic       r_rx_cmd_valid;
  logic [7:0] r_rx_data;
  logic       r_rx_data_valid;
  logic       w_rx_en;

  // Tracks the bus even during reset so turnaround stays meaningful afterwards.
  always_ff @(posedge clk) begin
    r_dir_q <= i_dir;
  end

  assign o_turnaround = i_dir ^ r_dir_q;
  assign w_rx_en      = i_dir && !o_turnaround && !i_suppress;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cmd        <= 8'h00;
      r_rx_cmd_valid  <= 1'b0;
      r_rx_data       <= 8'h00;
      r_rx_data_valid <= 1'b0;
    end else begin
      r_rx_cmd_valid  <= w_rx_en && !i_nxt;
      r_rx_data_valid <= w_rx_en && i_nxt;
      if (w_rx_en && !i_nxt) r_rx_cmd  <= i_data;
      if (w_rx_en && i_nxt)  r_rx_data <= i_data;
    end
  end

  assign o_rx_cmd        = r_rx_cmd;
  assign o_rx_cmd_valid  = r_rx_cmd_valid;
  assign o_rx_data       = r_rx_data;
  assign o_rx_data_valid = r_rx_data_valid;

endmodule
`default_nettype wire

// File: rtl/ulpi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_link_ctrl
// Purpose  : ULPI link-side register access engine with RX CMD/data decode.
//            Define ULPI_EXT_REG_EN for extended (8-bit) register addresses.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_link_ctrl
  import ulpi_pkg::*;
#(
  parameter int NXT_TIMEOUT = 15,
  parameter int REG_ADDR_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ulpi_dir,
  input  logic                  ulpi_nxt,
  input  logic [7:0]            ulpi_data_i,
  output logic [7:0]            ulpi_data_o,
  output logic                  ulpi_data_oe,
  output logic                  ulpi_stp,
  input  logic                  reg_req,
  input  logic                  reg_we,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic                  reg_ack,
  output logic [7:0]            reg_rdata,
  output logic                  reg_err,
  output logic [7:0]            rx_cmd,
  output logic                  rx_cmd_valid,
  output logic [7:0]            rx_data,
  output logic                  rx_data_valid
);

  localparam int c_cnt_w = $clog2(NXT_TIMEOUT + 1);

  ulpi_state_t           r_state, w_next, w_after_cmd, w_post_addr;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic                  r_ack, r_err;
  logic [7:0]            r_rdata;
  logic                  w_turn, w_tmo, w_launch, w_wait, w_done, w_err, w_capture, w_stp;
  logic [7:0]            w_data_o, w_txcmd;

  ulpi_rx_decode u_rx_decode (
    .clk             (clk),
    .reset           (reset),
    .i_dir           (ulpi_dir),
    .i_nxt           (ulpi_nxt),
    .i_data          (ulpi_data_i),
    .i_suppress      ((r_state == ST_RD_TURN) || (r_state == ST_RD_DATA)),
    .o_turnaround    (w_turn),
    .o_rx_cmd        (rx_cmd),
    .o_rx_cmd_valid  (rx_cmd_valid),
    .o_rx_data       (rx_data),
    .o_rx_data_valid (rx_data_valid)
  );

  assign w_post_addr = r_we ? ST_WDATA : ST_RD_TURN;

`ifdef ULPI_EXT_REG_EN
  logic w_ext;
  assign w_ext       = (r_addr >= REG_ADDR_W'(8'h3F));
  assign w_txcmd     = txcmd_byte(r_we, w_ext ? c_ext_escape : r_addr[5:0]);
  assign w_after_cmd = w_ext ? ST_EXT_ADDR : w_post_addr;
`else
  assign w_txcmd     = txcmd_byte(r_we, r_addr[5:0]);
  assign w_after_cmd = w_post_addr;
`endif

  assign w_tmo = (r_cnt == c_cnt_w'(NXT_TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    w_data_o  = c_noop;
    w_stp     = 1'b0;
    w_launch  = 1'b0;
    w_wait    = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      // r_ack blocks a relaunch while the requester is still seeing its ack.
      ST_IDLE: begin
        if (reg_req && !ulpi_dir && !w_turn && !r_ack) begin
          w_next   = ST_TXCMD;
          w_launch = 1'b1;
        end
      end
      ST_TXCMD: begin
        w_data_o = w_txcmd;
        w_wait   = 1'b1;
        if (ulpi_dir)      w_next = ST_IDLE;
        else if (ulpi_nxt) w_next = w_after_cmd;
        else if (w_tmo) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
`ifdef ULPI_EXT_REG_EN
      ST_EXT_ADDR: begin
        w_data_o = r_addr[7:0];
        w_wait   = 1'b1;
        if (ulpi_dir)      w_next = ST_IDLE;
        else if (ulpi_nxt) w_next = w_post_addr;
        else if (w_tmo) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
`endif
      ST_WDATA: begin
        w_data_o = r_wdata;
        w_wait   = 1'b1;
        if (ulpi_dir)      w_next = ST_IDLE;
        else if (ulpi_nxt) w_next = ST_STP;
        else if (w_tmo) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
      ST_STP: begin
        w_stp  = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_RD_TURN: w_next = ST_RD_DATA;
      ST_RD_DATA: begin
        w_capture = 1'b1;
        w_done    = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'h00;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_next;
      r_ack   <= w_done;
      r_err   <= w_err;
      if (w_next != r_state)      r_cnt <= '0;
      else if (w_wait && !ulpi_nxt) r_cnt <= r_cnt + c_cnt_w'(1);
      if (w_launch) begin
        r_we    <= reg_we;
        r_addr  <= reg_addr;
        r_wdata <= reg_wdata;
      end
      if (w_capture) r_rdata <= ulpi_data_i;
    end
  end

  assign ulpi_data_oe = !ulpi_dir && !w_turn;
  assign ulpi_data_o  = w_data_o;
  assign ulpi_stp     = w_stp;
  assign reg_ack      = r_ack;
  assign reg_err      = r_err;
  assign reg_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_link_ctrl
// Purpose  : Self-checking bench with a cycle-level PHY model and scoreboard
//            queues. Define ULPI_EXT_REG_EN to add the extended-address test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_link_ctrl;

`ifdef ULPI_EXT_REG_EN
  localparam int c_addr_w = 8;
`else
  localparam int c_addr_w = 6;
`endif
  localparam int c_timeout = 15;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
  logic [7:0]          ulpi_data_i = 8'h00;
  logic [7:0]          ulpi_data_o;
  logic                ulpi_data_oe, ulpi_stp;
  logic                reg_req = 1'b0, reg_we = 1'b0;
  logic [c_addr_w-1:0] reg_addr = '0;
  logic [7:0]          reg_wdata = 8'h00;
  logic                reg_ack, reg_err;
  logic [7:0]          reg_rdata, rx_cmd, rx_data;
  logic                rx_cmd_valid, rx_data_valid;

  int errors = 0;
  int checks = 0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] q_bytes[$];
  logic [8:0] q_resp[$];
  logic [7:0] q_rx[$];

  ulpi_link_ctrl #(.NXT_TIMEOUT(c_timeout), .REG_ADDR_W(c_addr_w)) dut (
    .clk(clk), .reset(reset),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe),
    .ulpi_stp(ulpi_stp),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
    .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid), .rx_data(rx_data), .rx_data_valid(rx_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (ulpi_stp !== 1'b0)      begin errors++; $display("FAIL reset_stp: got %b want 0", ulpi_stp); end
    checks++; if (ulpi_data_o !== 8'h00)  begin errors++; $display("FAIL reset_data_o: got %h want 00", ulpi_data_o); end
    checks++; if (ulpi_data_oe !== 1'b1)  begin errors++; $display("FAIL reset_oe: got %b want 1", ulpi_data_oe); end
    checks++; if (reg_ack !== 1'b0)       begin errors++; $display("FAIL reset_ack: got %b want 0", reg_ack); end
    checks++; if (reg_err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", reg_err); end
    checks++; if (reg_rdata !== 8'h00)    begin errors++; $display("FAIL reset_rdata: got %h want 00", reg_rdata); end
    checks++; if (rx_cmd_valid !== 1'b0 || rx_data_valid !== 1'b0)
      begin errors++; $display("FAIL reset_valids: got %b%b want 00", rx_cmd_valid, rx_data_valid); end
    checks++; if (rx_cmd !== 8'h00 || rx_data !== 8'h00)
      begin errors++; $display("FAIL reset_rx: got %h/%h want 00/00", rx_cmd, rx_data); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Write with a PHY that raises nxt one cycle after each new byte.
  task automatic test_write(input logic [c_addr_w-1:0] a, input logic [7:0] d, input string tag);
    logic seen; int nstp; bit done; logic [8:0] er; logic [7:0] eb;
    q_resp.push_back({1'b0, m_rdata});
    seen = 1'b0; nstp = 0; done = 1'b0;
    reg_we = 1'b1; reg_addr = a; reg_wdata = d; reg_req = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      ulpi_nxt = seen; #1;
      if (ulpi_stp) nstp++;
      if (reg_ack) begin
        done = 1'b1; reg_req = 1'b0;
        er = (q_resp.size() > 0) ? q_resp.pop_front() : 9'h1FF;
        checks++; if (reg_err !== er[8])        begin errors++; $display("FAIL %s_err: got %b want %b", tag, reg_err, er[8]); end
        checks++; if (reg_rdata !== er[7:0])    begin errors++; $display("FAIL %s_rdata: got %h want %h", tag, reg_rdata, er[7:0]); end
      end else if (ulpi_nxt && ulpi_data_oe) begin
        eb = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'hEE;
        checks++; if (ulpi_data_o !== eb)       begin errors++; $display("FAIL %s_byte: got %h want %h", tag, ulpi_data_o, eb); end
      end
      seen = ulpi_data_oe && !ulpi_stp && !ulpi_nxt && (ulpi_data_o != 8'h00);
    end
    ulpi_nxt = 1'b0; reg_req = 1'b0;
    checks++; if (!done)                begin errors++; $display("FAIL %s_ack_timeout: got no ack want ack", tag); end
    checks++; if (nstp != 1)            begin errors++; $display("FAIL %s_stp_cycles: got %0d want 1", tag, nstp); end
    checks++; if (q_bytes.size() != 0)  begin errors++; $display("FAIL %s_bytes_left: got %0d want 0", tag, q_bytes.size()); end
    q_bytes.delete(); q_resp.delete();
    @(posedge clk); #2;
    checks++; if (reg_ack !== 1'b0)     begin errors++; $display("FAIL %s_ack_b2b: got %b want 0", tag, reg_ack); end
  endtask

  task automatic test_read();
    logic seen; int ph, nrx; bit done; logic [8:0] er; logic [7:0] eb;
    q_bytes.push_back(8'hD6);
    q_resp.push_back({1'b0, 8'hC3});
    seen = 1'b0; ph = 0; nrx = 0; done = 1'b0;
    reg_we = 1'b0; reg_addr = c_addr_w'(8'h16); reg_req = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      case (ph)
        1: begin ulpi_dir = 1'b1; ulpi_nxt = 1'b0; ph = 2; end
        2: begin ulpi_data_i = 8'hC3; ph = 3; end
        3: begin ulpi_dir = 1'b0; ulpi_data_i = 8'h00; ph = 4; end
        default: ulpi_nxt = seen;
      endcase
      #1;
      if (rx_cmd_valid || rx_data_valid) nrx++;
      if (reg_ack) begin
        done = 1'b1; reg_req = 1'b0;
        er = (q_resp.size() > 0) ? q_resp.pop_front() : 9'h1FF;
        checks++; if (reg_err !== er[8])     begin errors++; $display("FAIL read_err: got %b want %b", reg_err, er[8]); end
        checks++; if (reg_rdata !== er[7:0]) begin errors++; $display("FAIL read_rdata: got %h want %h", reg_rdata, er[7:0]); end
      end else if (ph == 0 && ulpi_nxt && ulpi_data_oe) begin
        eb = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'hEE;
        checks++; if (ulpi_data_o !== eb)    begin errors++; $display("FAIL read_txcmd: got %h want %h", ulpi_data_o, eb); end
        ph = 1;
      end
      seen = ulpi_data_oe && !ulpi_nxt && (ulpi_data_o != 8'h00);
    end
    ulpi_nxt = 1'b0; ulpi_dir = 1'b0;
    repeat (2) begin
      @(posedge clk); #2;
      if (rx_cmd_valid || rx_data_valid) nrx++;
    end
    checks++; if (!done)   begin errors++; $display("FAIL read_ack_timeout: got no ack want ack"); end
    checks++; if (nrx != 0) begin errors++; $display("FAIL read_rx_valid: got %0d pulses want 0", nrx); end
    m_rdata = 8'hC3;
    q_bytes.delete(); q_resp.delete();
  endtask

  task automatic test_timeout();
    int n8a, nstp; bit done; logic [8:0] er;
    q_resp.push_back({1'b1, m_rdata});
    n8a = 0; nstp = 0; done = 1'b0;
    reg_we = 1'b1; reg_addr = c_addr_w'(8'h0A); reg_wdata = 8'h55; reg_req = 1'b1;
    ulpi_nxt = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #2;
      if (ulpi_stp) nstp++;
      if (ulpi_data_oe && ulpi_data_o == 8'h8A) n8a++;
      if (reg_ack) begin
        done = 1'b1; reg_req = 1'b0;
        er = (q_resp.size() > 0) ? q_resp.pop_front() : 9'h0FF;
        checks++; if (reg_err !== er[8])     begin errors++; $display("FAIL tmo_err: got %b want %b", reg_err, er[8]); end
        checks++; if (reg_rdata !== er[7:0]) begin errors++; $display("FAIL tmo_rdata: got %h want %h", reg_rdata, er[7:0]); end
      end
    end
    reg_req = 1'b0;
    checks++; if (!done)            begin errors++; $display("FAIL tmo_ack_timeout: got no ack want ack"); end
    checks++; if (n8a != c_timeout) begin errors++; $display("FAIL tmo_wait_cycles: got %0d want %0d", n8a, c_timeout); end
    checks++; if (nstp != 0)        begin errors++; $display("FAIL tmo_stp: got %0d want 0", nstp); end
    q_resp.delete();
    @(posedge clk); #1;
  endtask

  // PHY takes the bus with an RX CMD while the link is presenting its data byte.
  task automatic test_abort();
    logic seen; int ab, nstp, nrx; bit done; logic [8:0] er; logic [7:0] eb;
    q_bytes.push_back(8'h8A); q_bytes.push_back(8'h8A); q_bytes.push_back(8'h55);
    q_resp.push_back({1'b0, m_rdata});
    q_rx.push_back(8'h4E);
    seen = 1'b0; ab = 0; nstp = 0; nrx = 0; done = 1'b0;
    reg_we = 1'b1; reg_addr = c_addr_w'(8'h0A); reg_wdata = 8'h55; reg_req = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      case (ab)
        1: begin ulpi_dir = 1'b1; ulpi_nxt = 1'b0; ab = 2; end
        2: begin ulpi_data_i = 8'h4E; ab = 3; end
        3: begin ulpi_dir = 1'b0; ulpi_data_i = 8'h00; ab = 4; end
        default: ulpi_nxt = seen;
      endcase
      #1;
      if (ulpi_stp) nstp++;
      if (rx_cmd_valid) begin
        nrx++;
        eb = (q_rx.size() > 0) ? q_rx.pop_front() : 8'hEE;
        checks++; if (rx_cmd !== eb) begin errors++; $display("FAIL abort_rx_cmd: got %h want %h", rx_cmd, eb); end
      end
      if (reg_ack) begin
        done = 1'b1; reg_req = 1'b0;
        er = (q_resp.size() > 0) ? q_resp.pop_front() : 9'h1FF;
        checks++; if (reg_err !== er[8])     begin errors++; $display("FAIL abort_err: got %b want %b", reg_err, er[8]); end
        checks++; if (reg_rdata !== er[7:0]) begin errors++; $display("FAIL abort_rdata: got %h want %h", reg_rdata, er[7:0]); end
      end else if (ulpi_nxt && ulpi_data_oe) begin
        eb = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'hEE;
        checks++; if (ulpi_data_o !== eb) begin errors++; $display("FAIL abort_byte: got %h want %h", ulpi_data_o, eb); end
      end
      seen = ulpi_data_oe && !ulpi_stp && !ulpi_nxt && (ulpi_data_o != 8'h00);
      if (ab == 0 && seen && ulpi_data_o == 8'h55) begin
        ab = 1; seen = 1'b0;
      end
    end
    ulpi_nxt = 1'b0; reg_req = 1'b0;
    checks++; if (!done)               begin errors++; $display("FAIL abort_ack_timeout: got no ack want ack"); end
    checks++; if (nrx != 1)            begin errors++; $display("FAIL abort_rx_count: got %0d want 1", nrx); end
    checks++; if (nstp != 1)           begin errors++; $display("FAIL abort_stp_cycles: got %0d want 1", nstp); end
    checks++; if (q_bytes.size() != 0) begin errors++; $display("FAIL abort_bytes_left: got %0d want 0", q_bytes.size()); end
    q_bytes.delete(); q_resp.delete(); q_rx.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen; bit trig; int nack;
    seen = 1'b0; trig = 1'b0; nack = 0;
    reg_we = 1'b1; reg_addr = c_addr_w'(8'h0A); reg_wdata = 8'h55; reg_req = 1'b1;
    for (int c = 0; c < 40 && !trig; c++) begin
      @(posedge clk); #1;
      ulpi_nxt = seen; #1;
      if (reg_ack) nack++;
      if (ulpi_data_oe && !ulpi_nxt && ulpi_data_o == 8'h55) trig = 1'b1;
      seen = ulpi_data_oe && !ulpi_nxt && (ulpi_data_o != 8'h00);
    end
    checks++; if (!trig) begin errors++; $display("FAIL rstmid_reach_wdata: got no data byte want 55"); end
    @(posedge clk); #1;
    ulpi_nxt = 1'b0; reset = 1'b1; reg_req = 1'b0;
    @(posedge clk); #2;
    checks++; if (ulpi_stp !== 1'b0)     begin errors++; $display("FAIL rstmid_stp: got %b want 0", ulpi_stp); end
    checks++; if (ulpi_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data_o: got %h want 00", ulpi_data_o); end
    checks++; if (reg_rdata !== 8'h00)   begin errors++; $display("FAIL rstmid_rdata: got %h want 00", reg_rdata); end
    checks++; if (reg_err !== 1'b0)      begin errors++; $display("FAIL rstmid_err: got %b want 0", reg_err); end
    m_rdata = 8'h00;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #2;
      if (reg_ack) nack++;
    end
    checks++; if (nack != 0)             begin errors++; $display("FAIL rstmid_ack: got %0d acks want 0", nack); end
    checks++; if (ulpi_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_idle: got %h want 00", ulpi_data_o); end
  endtask

  initial begin
    test_reset();
    q_bytes.push_back(8'h8A); q_bytes.push_back(8'h55);
    test_write(c_addr_w'(8'h0A), 8'h55, "write");
    test_read();
    test_timeout();
    test_abort();
`ifdef ULPI_EXT_REG_EN
    q_bytes.push_back(8'hAF); q_bytes.push_back(8'h80); q_bytes.push_back(8'h01);
    test_write(c_addr_w'(8'h80), 8'h01, "ext_write");
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
